alu_key_scheduler: RTL
======================

// Module: alu_key_scheduler
// PURPOSE
//   Owns the 96-bit key fed to the chaotic ALU core in EX. Software stages a new key
//   as three 32-bit words into a shadow bank, then commits. The swap lands only when
//   EX holds no valid ALU op. If EX stays busy past a timeout, the block requests a
//   pipeline stall to force a safe point. The live key never changes under an in-flight op.
// PARAMETERS
//   KEY_W          96      live/shadow key width (fixed 3 x WORD_W)
//   WORD_W         32      staging write width
//   DRAIN_TIMEOUT  16      PEND cycles without ex_idle before stall_req asserts (>=1)
//   RESET_KEY      96'h0   live key value after Rst
// PORTS
//   clk        in   1       core clock
//   Rst        in   1       synchronous active-high reset
//   wr_en      in   1       staging/control write strobe
//   wr_addr    in   2       0,1,2 = key word [31:0],[63:32],[95:64]; 3 = control
//   wr_data    in   32      write data; ctrl: bit0 COMMIT, bit1 ABORT
//   wr_ready   out  1       1 in IDLE/LOAD; writes with wr_ready=0 are dropped
//   ex_idle    in   1       no valid ALU op in ID/EX this cycle
//   stall_req  out  1       request to freeze IF/ID (registered)
//   key        out  96      live key to ALU core (registered)
//   swap_done  out  1       one-cycle pulse, cycle after the key update
//   epoch      out  8       count of completed swaps, wraps 255->0
//   status     out  8       {err, busy, mask[2:0], 1'b0, state[1:0]}
// BEHAVIOUR
//   Reset (sync; also mid-operation): key=RESET_KEY, shadow=0, mask=0, err=0, state=IDLE,
//     stall_req=0, swap_done=0, epoch=0, drain counter=0. Any pending swap is lost.
//   States (2-bit): IDLE=0, LOAD=1, PEND=2, DRAIN=3. busy=1 in PEND/DRAIN.
//   IDLE/LOAD, accepted word write (addr 0-2):
//     - shadow word <= wr_data, mask[addr] <= 1, state -> LOAD.
//     - Rewriting a word overwrites it.
//   Control write (addr 3):
//     - ABORT: shadow=0, mask=0, err=0 -> IDLE. ABORT wins over COMMIT in the same write.
//     - COMMIT with mask==3'b111: -> PEND, drain counter=0.
//     - COMMIT with mask!=3'b111: err <= 1 (sticky until ABORT/Rst), state unchanged.
//   PEND:
//     - ex_idle=1: on this edge key <= shadow, epoch++, shadow=0, mask=0 -> IDLE;
//       swap_done=1 next cycle.
//     - else counter++. When counter==DRAIN_TIMEOUT-1 and ex_idle=0 -> DRAIN.
//   DRAIN: stall_req=1 while in DRAIN. ex_idle=1 -> same swap action as PEND;
//     stall_req=0 from the following cycle.
//   ex_idle and timeout in the same cycle: the swap wins; DRAIN is never entered.
//   Latency: COMMIT accepted at edge T (-> PEND).
//     - ex_idle high from T: key new in the cycle after edge T+1.
//     - swap_done is high in that same cycle.
//   Arithmetic: epoch is mod 2^8. The counter saturates at DRAIN_TIMEOUT-1 and resets on PEND entry.
//   The key output holds its value outside swap edges; there are no partial-word updates to live key.
// STRUCTURE
//   Package alu_key_pkg:
//     - typedef enum logic [1:0] {IDLE, LOAD, PEND, DRAIN} key_state_t
//     - localparams ADDR_W0..ADDR_W2, ADDR_CTRL, CTRL_COMMIT_BIT=0, CTRL_ABORT_BIT=1
//   One sub-module: alu_key_drain_timer (counter + timeout flag; inputs: clear, enable).
//   FSM, shadow bank and live key register stay in this module.
// TESTING
//   1 Reset: Rst 1 cycle -> key=0, epoch=0, status=0, wr_ready=1, stall_req=0.
//   2 Happy path: write A5A5A5A5/3C3C3C3C/0F0F0F0F to addr 0/1/2, COMMIT, ex_idle=1
//     -> key=0F0F0F0F_3C3C3C3C_A5A5A5A5 two cycles after COMMIT, swap_done 1 cycle,
//        epoch=1, no stall.
//   3 Incomplete: write word 0 and word 2 only, COMMIT -> err=1, state LOAD, key unchanged.
//     Then write word 1, COMMIT -> swap.
//   4 Drain: full load, COMMIT, ex_idle=0 for 20 cycles -> stall_req rises after 16 PEND
//     cycles. ex_idle=1 -> key updates, stall_req low the next cycle.
//   5 Abort/drop: COMMIT+ABORT in one write -> IDLE, mask=0. Writes during PEND are ignored
//     (shadow unchanged). Rst in DRAIN -> stall_req=0 and key=RESET_KEY next cycle.
//   6 Wrap: 256 back-to-back swaps -> epoch returns to 0; each swap_done exactly 1 cycle.

Source files
------------

// File: rtl/alu_key_pkg.sv
// alu_key_pkg
//   Shared types and constants for the ALU key scheduler.
//   key_state_t : 2-bit FSM state encoding (IDLE=0, LOAD=1, PEND=2, DRAIN=3)
//   ADDR_*      : staging/control write address map
//   CTRL_*_BIT  : bit positions inside a control-word write
package alu_key_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PEND  = 2'd2,
    DRAIN = 2'd3
  } key_state_t;

  localparam logic [1:0] ADDR_W0   = 2'd0;
  localparam logic [1:0] ADDR_W1   = 2'd1;
  localparam logic [1:0] ADDR_W2   = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_ABORT_BIT  = 1;

endpackage

// File: rtl/alu_key_drain_timer.sv
// alu_key_drain_timer
//   Counts PEND cycles spent waiting for EX to go idle. Saturates at
//   DRAIN_TIMEOUT-1 and flags the terminal count.
//   clk     in  core clock
//   Rst     in  synchronous active-high reset
//   clear   in  restart count from 0 (PEND entry)
//   enable  in  advance count by one this cycle
//   timeout out count has reached DRAIN_TIMEOUT-1
module alu_key_drain_timer #(
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DRAIN_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign timeout = (cnt_q == LIMIT);

  always_ff @(posedge clk) begin
    if (Rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !timeout) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_key_scheduler.sv
// alu_key_scheduler
//   Stages a 96-bit ALU key as three 32-bit words in a shadow bank and swaps
//   it into the live key only at a cycle where EX holds no valid op. If EX
//   stays busy for DRAIN_TIMEOUT PEND cycles, a pipeline stall is requested.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no words staged, accepting writes
//   LOAD  | some words staged, accepting writes / control
//   PEND  | commit accepted, waiting for ex_idle (writes dropped)
//   DRAIN | timeout hit, stall_req asserted until ex_idle
//
//   clk, Rst             clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data staging and control writes (addr 3 = control)
//   wr_ready             writes accepted (IDLE/LOAD)
//   ex_idle              no valid ALU op in ID/EX this cycle
//   stall_req            registered stall request to IF/ID
//   key                  live key (registered)
//   swap_done            one-cycle pulse after a key update
//   epoch                completed swap count (mod 256)
//   status               {err, busy, mask[2:0], 1'b0, state[1:0]}
module alu_key_scheduler
  import alu_key_pkg::*;
#(
  parameter int               KEY_W         = 96,
  parameter int               WORD_W        = 32,
  parameter int               DRAIN_TIMEOUT = 16,
  parameter logic [KEY_W-1:0] RESET_KEY     = '0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              ex_idle,
  output logic              stall_req,
  output logic [KEY_W-1:0]  key,
  output logic              swap_done,
  output logic [7:0]        epoch,
  output logic [7:0]        status
);

  key_state_t       state_q;
  logic [KEY_W-1:0] shadow_q;
  logic [2:0]       mask_q;
  logic             err_q;

  logic wr_acc, ctrl_wr, abort, commit, commit_ok, busy, swap, timeout;

  assign wr_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign busy      = (state_q == PEND) || (state_q == DRAIN);
  assign wr_acc    = wr_en && wr_ready;
  assign ctrl_wr   = wr_acc && (wr_addr == ADDR_CTRL);
  assign abort     = ctrl_wr && wr_data[CTRL_ABORT_BIT];
  // ABORT takes priority when both control bits are set in one write
  assign commit    = ctrl_wr && wr_data[CTRL_COMMIT_BIT] && !abort;
  assign commit_ok = commit && (mask_q == 3'b111);
  assign swap      = busy && ex_idle;
  assign status    = {err_q, busy, mask_q, 1'b0, state_q};

  alu_key_drain_timer #(
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_drain_timer (
    .clk     (clk),
    .Rst     (Rst),
    .clear   (commit_ok),
    .enable  ((state_q == PEND) && !ex_idle),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      mask_q    <= '0;
      err_q     <= 1'b0;
      key       <= RESET_KEY;
      epoch     <= '0;
      stall_req <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      if (swap) begin
        // swap beats a same-cycle timeout, so DRAIN is never entered then
        key       <= shadow_q;
        epoch     <= epoch + 8'd1;
        shadow_q  <= '0;
        mask_q    <= '0;
        state_q   <= IDLE;
        stall_req <= 1'b0;
        swap_done <= 1'b1;
      end else if ((state_q == PEND) && timeout) begin
        state_q   <= DRAIN;
        stall_req <= 1'b1;
      end else if (abort) begin
        shadow_q <= '0;
        mask_q   <= '0;
        err_q    <= 1'b0;
        state_q  <= IDLE;
      end else if (commit) begin
        if (commit_ok) begin
          state_q <= PEND;
        end else begin
          err_q <= 1'b1;
        end
      end else if (wr_acc && !ctrl_wr) begin
        state_q <= LOAD;
        case (wr_addr)
          ADDR_W0: begin
            shadow_q[WORD_W-1:0] <= wr_data;
            mask_q[0]            <= 1'b1;
          end
          ADDR_W1: begin
            shadow_q[2*WORD_W-1:WORD_W] <= wr_data;
            mask_q[1]                   <= 1'b1;
          end
          default: begin
            shadow_q[3*WORD_W-1:2*WORD_W] <= wr_data;
            mask_q[2]                     <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
